reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port integer register file with an integrated per-register scoreboard, for the pipelined core. Holds architectural register state, tracks which destination registers have an in-flight producer (set at issue, cleared at writeback), and reports per-operand busy status so the issue stage can stall on RAW/WAW hazards. Register 0 is hard-wired to zero and never busy.

## Interface

- XLEN, 32: data width in bits.
- NREGS, 32: number of registers; power of two, ≥ 2.
- NRD, 2: number of read ports, 1–4.
- AW, $clog2(NREGS): address width (derived; not overridden).

- clk  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high; sampled on rising edge of clk.
- rs_addr  in  NRD*AW: read addresses; port i at [i*AW +: AW].
- rs_data  out  NRD*XLEN: read data; port i at [i*XLEN +: XLEN].
- rs_busy  out  NRD: port i's register has a pending producer.
- iss_valid  in  1: issue stage requests reservation of iss_rd.
- iss_rd  in  AW: destination register to reserve.
- iss_ready  out  1: reservation can be accepted this cycle.
- wb_valid  in  1: writeback of wb_data to wb_rd.
- wb_rd  in  AW: writeback destination.
- wb_data  in  XLEN: writeback data.
- flush  in  1: clear all pending reservations (pipeline flush).
- pend_cnt  out  $clog2(NREGS+1): number of registers currently busy.

## Operation

- State: data array mem[0..NREGS-1], busy vector busy[NREGS-1:0], counter pend_cnt.
- Read (combinational): rs_data[i] = 0 if rs_addr[i]==0, else mem[rs_addr[i]]; rs_busy[i] = busy[rs_addr[i]] (busy[0] is constant 0).
- iss_ready = (iss_rd==0) | ~busy[iss_rd] | (wb_valid & wb_rd==iss_rd). WAW stall otherwise.
- Issue accepted = iss_valid & iss_ready & ~flush. If iss_rd != 0, sets busy[iss_rd]. Issue to x0 is accepted and has no effect.
- Writeback: wb_valid & wb_rd != 0 writes mem[wb_rd] <= wb_data and clears busy[wb_rd]. Writeback to x0 is ignored.
- Simultaneous accepted issue and writeback to same register: data written, busy ends 1 (new producer wins).
- flush: all busy bits cleared next edge; accepted issue suppressed; writeback data in same cycle still written.
- pend_cnt = popcount of busy, maintained as a registered counter: +1 on set of a clear bit, −1 on clear of a set bit, net 0 when both on the same register or on different registers in the same cycle; 0 after flush. Never exceeds NREGS−1.
- Reset: mem all zero, busy all zero, pend_cnt 0. Reset overrides issue, writeback and flush.

## Timing

- Reads: zero-cycle combinational from rs_addr and registered state.
- Writeback: data visible on read ports the cycle after wb_valid (without bypass); busy clear visible the same following cycle.
- Issue: busy visible on rs_busy and pend_cnt the cycle after acceptance.
- iss_ready: combinational from iss_rd, busy, wb_valid, wb_rd; no dependence on iss_valid.
- Outputs during/after reset cycle: rs_data 0, rs_busy 0, iss_ready 1, pend_cnt 0.

## Configuration

- REGFILE_BYPASS_EN defined: write-to-read forwarding. When wb_valid & wb_rd==rs_addr[i] & rs_addr[i]!=0, rs_data[i] = wb_data and rs_busy[i] = 0 in the same cycle; readers see writeback with zero latency.
- Not defined: no forwarding; read ports reflect registered state only, writeback visible one cycle later. All other behaviour identical.

## Test plan

- Reset, then write x5=0xDEADBEEF via wb; next cycle rs_addr0=5 -> rs_data0=0xDEADBEEF, rs_busy0=0; rs_addr1=0 -> 0.
- wb_valid to x0 with 0xFFFFFFFF -> rs_data for x0 stays 0; pend_cnt unchanged.
- Issue x7; next cycle rs_busy for x7=1, pend_cnt=1, iss_ready=0 for iss_rd=7; wb x7=0x1234 -> next cycle busy 0, pend_cnt 0, data 0x1234.
- Busy x7, same cycle issue x7 and wb x7=0x55 -> iss_ready=1, next cycle busy[7]=1, pend_cnt=1, data 0x55.
- Issue x1,x2,x3 on successive cycles (pend_cnt=3), then flush with iss_valid x4 and wb x2=0x9 -> next cycle pend_cnt=0, x4 not busy, x2=0x9.
- With REGFILE_BYPASS_EN: rs_addr0=9 while wb x9=0xA5A5A5A5 -> same cycle rs_data0=0xA5A5A5A5, rs_busy0=0; without macro -> old value same cycle, new value next cycle.

Source files
------------

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_file_sb_if                                            |
// | Purpose  : Bus bundle between the issue/writeback stages and the     |
// |            register file with scoreboard.                            |
// | Signals  : rs_addr/rs_data/rs_busy - NRD packed read ports           |
// |            iss_valid/iss_rd/iss_ready - destination reservation      |
// |            wb_valid/wb_rd/wb_data     - writeback                    |
// |            flush                      - drop all reservations        |
// |            pend_cnt                   - number of busy registers     |
// | Modports : master (pipeline side), slave (register file side)        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [CW-1:0]       pend_cnt;

  modport master (
    output rs_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
    input  rs_data, rs_busy, iss_ready, pend_cnt
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, flush,
    output rs_data, rs_busy, iss_ready, pend_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_file_sb                                               |
// | Purpose  : Multi-read-port integer register file with a per-register |
// |            scoreboard. Destinations are marked busy at issue and     |
// |            cleared at writeback; read ports report busy status so    |
// |            the issue stage can stall on RAW/WAW hazards. x0 reads as |
// |            zero and is never busy.                                   |
// | Ports    : clk   - clock, all state updates on rising edge           |
// |            reset - synchronous active-high reset                     |
// |            bus   - reg_file_sb_if.slave (read ports, issue,          |
// |                    writeback, flush, pending count)                  |
// | Options  : REGFILE_BYPASS_EN - forward same-cycle writeback data to  |
// |            the read ports and mask their busy flag.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_sb_if.slave    bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [CW-1:0]    cnt;

  logic wb_en;
  logic wb_hits_iss;
  logic iss_ready;
  logic iss_set;
  logic cnt_inc;
  logic cnt_dec;

  assign wb_en       = bus.wb_valid && (bus.wb_rd != '0);
  assign wb_hits_iss = bus.wb_valid && (bus.wb_rd == bus.iss_rd);

  // A busy destination may be re-reserved when its producer retires in the
  // same cycle: the old value lands and the new producer takes ownership.
  assign iss_ready = (bus.iss_rd == '0) || !busy[bus.iss_rd] || wb_hits_iss;
  assign iss_set   = bus.iss_valid && iss_ready && !bus.flush && (bus.iss_rd != '0);

  // Counter follows the popcount of busy: only real 0->1 and 1->0 transitions
  // move it. A clear that is immediately re-set on the same register is no
  // transition at all.
  assign cnt_inc = iss_set && !busy[bus.iss_rd];
  assign cnt_dec = wb_en && busy[bus.wb_rd] && !(iss_set && (bus.iss_rd == bus.wb_rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      // Writeback data is committed even during a flush.
      if (wb_en) begin
        mem[bus.wb_rd] <= bus.wb_data;
      end
      if (bus.flush) begin
        busy <= '0;
        cnt  <= '0;
      end else begin
        if (wb_en) begin
          busy[bus.wb_rd] <= 1'b0;
        end
        // Later assignment wins: a new producer overrides a same-cycle clear.
        if (iss_set) begin
          busy[bus.iss_rd] <= 1'b1;
        end
        cnt <= cnt + CW'(cnt_inc) - CW'(cnt_dec);
      end
    end
  end

  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          fwd;

    assign addr = bus.rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign fwd = bus.wb_valid && (bus.wb_rd == addr) && (addr != '0);
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                     fwd          ? bus.wb_data : mem[addr];
    // busy[0] can never be set, so x0 always reads as not busy.
    assign rd_busy[i] = busy[addr] && !fwd;
  end

  assign bus.rs_data   = rd_data;
  assign bus.rs_busy   = rd_busy;
  assign bus.iss_ready = iss_ready;
  assign bus.pend_cnt  = cnt;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reg_file_sb                                            |
// | Purpose  : Self-checking bench for reg_file_sb (XLEN=32, NREGS=32,   |
// |            NRD=2). Directed vector table plus short hand sequences   |
// |            for forwarding and WAW stall behaviour. Expectations      |
// |            adapt to REGFILE_BYPASS_EN.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_reg_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  a0, a1;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        fl;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1, e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(input int rst, input int a0, input int a1,
                              input int iv, input int ird, input int wv,
                              input int wrd, input logic [31:0] wd, input int fl,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input int b0, input int b1, input int rdy,
                              input int cnt);
    vec_t v;
    v.rst = 1'(rst);  v.a0 = 5'(a0);  v.a1 = 5'(a1);
    v.iv = 1'(iv);    v.ird = 5'(ird);
    v.wv = 1'(wv);    v.wrd = 5'(wrd); v.wd = wd;  v.fl = 1'(fl);
    v.e_d0 = d0;      v.e_d1 = d1;
    v.e_b0 = 1'(b0);  v.e_b1 = 1'(b1); v.e_rdy = 1'(rdy);
    v.e_cnt = 6'(cnt);
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    bus.rs_addr   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    reset         = v.rst;
    bus.rs_addr   = {v.a1, v.a0};
    bus.iss_valid = v.iv;
    bus.iss_rd    = v.ird;
    bus.wb_valid  = v.wv;
    bus.wb_rd     = v.wrd;
    bus.wb_data   = v.wd;
    bus.flush     = v.fl;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("rs_data0",  idx, bus.rs_data[31:0],  v.e_d0);
    chk("rs_data1",  idx, bus.rs_data[63:32], v.e_d1);
    chk("rs_busy0",  idx, 32'(bus.rs_busy[0]), 32'(v.e_b0));
    chk("rs_busy1",  idx, 32'(bus.rs_busy[1]), 32'(v.e_b1));
    chk("iss_ready", idx, 32'(bus.iss_ready),  32'(v.e_rdy));
    chk("pend_cnt",  idx, 32'(bus.pend_cnt),   32'(v.e_cnt));
  endtask

  initial begin
    // Each row: inputs held across one rising edge; expected outputs are the
    // combinational view just before that edge.
    //   rst a0 a1 iv ird wv wrd wd fl | d0 d1 b0 b1 rdy cnt
    add(0, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 1, 0);
    add(0, 5, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    add(0, 0, 5, 1, 7, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    add(0, 7, 0, 0, 7, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 7, 0, 0, 7, 1, 7, 32'h1234, 0, BYP ? 32'h1234 : 32'h0, 0, BYP ? 0 : 1, 0, 1, 1);
    add(0, 7, 0, 0, 7, 0, 0, 32'h0, 0, 32'h1234, 0, 0, 0, 1, 0);
    add(0, 7, 0, 1, 7, 0, 0, 32'h0, 0, 32'h1234, 0, 0, 0, 1, 0);
    add(0, 7, 0, 1, 7, 1, 7, 32'h55, 0, BYP ? 32'h55 : 32'h1234, 0, BYP ? 0 : 1, 0, 1, 1);
    add(0, 7, 7, 0, 7, 0, 0, 32'h0, 0, 32'h55, 32'h55, 1, 1, 0, 1);
    add(0, 7, 0, 0, 0, 1, 7, 32'h77, 0, BYP ? 32'h77 : 32'h55, 0, BYP ? 0 : 1, 0, 1, 1);
    add(0, 1, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 2, 0, 0, 32'h0, 0, 0, 0, 1, 0, 1, 1);
    add(0, 2, 0, 1, 3, 0, 0, 32'h0, 0, 0, 0, 1, 0, 1, 2);
    add(0, 2, 3, 1, 4, 1, 2, 32'h9, 1, BYP ? 32'h9 : 32'h0, 0, BYP ? 0 : 1, 1, 1, 3);
    add(0, 4, 2, 0, 1, 0, 0, 32'h0, 0, 0, 32'h9, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 6, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 5, 6, 1, 6, 1, 5, 32'h1, 0, BYP ? 32'h1 : 32'hDEADBEEF, 0, 0, 1, 0, 1);
    add(0, 5, 6, 0, 6, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0);

    // Reset state
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("reset pend_cnt",  -1, 32'(bus.pend_cnt), 32'h0);
    chk("reset iss_ready", -1, 32'(bus.iss_ready), 32'h1);
    chk("reset rs_busy",   -1, 32'(bus.rs_busy), 32'h0);
    bus.rs_addr = {5'd31, 5'd5};
    #1;
    chk("reset rs_data",   -1, bus.rs_data[31:0] | bus.rs_data[63:32], 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      apply(vq[i]);
      #2;
      check_vec(i, vq[i]);
    end

    // Forwarding: read x9 in the same cycle it is written back.
    @(negedge clk);
    idle(); reset = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h1;
    @(negedge clk);
    idle();
    bus.rs_addr  = {5'd0, 5'd9};
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hA5A5A5A5;
    #2;
    chk("fwd same-cycle data", 100, bus.rs_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h1);
    chk("fwd same-cycle busy", 100, 32'(bus.rs_busy[0]), 32'h0);
    @(negedge clk);
    idle();
    bus.rs_addr = {5'd0, 5'd9};
    #2;
    chk("fwd next-cycle data", 101, bus.rs_data[31:0], 32'hA5A5A5A5);

    // WAW stall: a second reservation of busy x10 must not be accepted.
    @(negedge clk);
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
    @(negedge clk);
    bus.rs_addr = {5'd0, 5'd10};
    #2;
    chk("waw iss_ready", 102, 32'(bus.iss_ready), 32'h0);
    chk("waw busy x10",  102, 32'(bus.rs_busy[0]), 32'h1);
    chk("waw pend_cnt",  102, 32'(bus.pend_cnt), 32'h1);
    // Retire x10 while reserving x11: count must stay at one.
    @(negedge clk);
    idle();
    bus.rs_addr   = {5'd11, 5'd10};
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd11;
    bus.wb_valid  = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'h3;
    #2;
    chk("mixed pend_cnt before", 103, 32'(bus.pend_cnt), 32'h1);
    chk("mixed iss_ready",       103, 32'(bus.iss_ready), 32'h1);
    @(negedge clk);
    idle();
    bus.rs_addr = {5'd11, 5'd10};
    #2;
    chk("mixed pend_cnt after", 104, 32'(bus.pend_cnt), 32'h1);
    chk("mixed busy x10",       104, 32'(bus.rs_busy[0]), 32'h0);
    chk("mixed busy x11",       104, 32'(bus.rs_busy[1]), 32'h1);
    chk("mixed data x10",       104, bus.rs_data[31:0], 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
